rmii_rx: RTL

//  RMII receive MAC front end, the counterpart of the frame transmitter on the same PHY link.

---
 rtl/rmii_rx_pkg.sv | 34 +++
 rtl/rmii_rx_if.sv | 24 ++
 rtl/rmii_crc32_dibit.sv | 21 ++
 rtl/rmii_rx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_pkg.sv
// Shared types and constants for the RMII receive path.
// Includes the bitwise CRC-32 dibit step used by the FCS checker.
package rmii_rx_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DROP
   } rx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;
   localparam logic [31:0] CRC32_POLY     = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB_20E3;
   localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;

   // Reflected CRC step; bit 0 of the dibit is first on the wire.
   function automatic logic [31:0] crc32_dibit(
      input logic [31:0] c,
      input logic [1:0]  d
   );
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 2; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ CRC32_POLY;
      end
      return r;
   endfunction

endpackage

// File: rtl/rmii_rx_if.sv
// Received byte stream plus end-of-frame status bundle.
// master = receiver front end, slave = consumer.
interface rmii_rx_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic        rx_crc_ok;
   logic        rx_err;
   logic [10:0] frame_len;
   logic [15:0] frame_cnt;

   modport master (
      output rx_data, rx_valid, rx_sof, rx_eof,
      output rx_crc_ok, rx_err, frame_len, frame_cnt
   );

   modport slave (
      input rx_data, rx_valid, rx_sof, rx_eof,
      input rx_crc_ok, rx_err, frame_len, frame_cnt
   );

endinterface

// File: rtl/rmii_crc32_dibit.sv
// CRC-32 register advanced two bits per clock.
// clear wins over enable and reloads the all-ones seed.
module rmii_crc32_dibit
   import rmii_rx_pkg::*;
(
   input  logic        clk_50MHz,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [1:0]  din,
   output logic [31:0] crc
);

   // CRC state register
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n)    crc <= CRC32_INIT;
      else if (clear)  crc <= CRC32_INIT;
      else if (enable) crc <= crc32_dibit(crc, din);
   end

endmodule

// File: rtl/rmii_rx.sv
// RMII receive front end: strips preamble/SFD, assembles bytes,
// checks FCS and length, reports status on a one-cycle rx_eof.
module rmii_rx
   import rmii_rx_pkg::*;
#(
   parameter int MIN_FRAME    = 64,
   parameter int MAX_FRAME    = 1518,
   parameter int PREAMBLE_MIN = 8
) (
   input  logic      clk_50MHz,
   input  logic      reset_n,
   input  logic      CRS_DV,
   input  logic      RX0,
   input  logic      RX1,
   rmii_rx_if.master rx
);

   logic        s_dv;
   logic [1:0]  s_d;
   rx_state_t   state_q, state_d;
   logic [4:0]  pre_cnt;
   logic [1:0]  phase;
   logic [10:0] byte_cnt;
   logic [5:0]  byte_sr;
   logic [31:0] crc_state, crc_lat, crc_byte;
   logic        crc_clr, crc_en;
   logic        byte_done, eof_set, align_err, ovf;
   logic        err_d, ok_d;

   rmii_crc32_dibit u_crc (
      .clk_50MHz (clk_50MHz),
      .reset_n   (reset_n),
      .clear     (crc_clr),
      .enable    (crc_en),
      .din       (s_d),
      .crc       (crc_state)
   );

   // Alignment-error frames are judged on the CRC at the last whole byte
   assign crc_byte = (phase == 2'd0) ? crc_state : crc_lat;
   assign err_d = ovf | align_err | (byte_cnt < 11'(MIN_FRAME));
   assign ok_d  = !ovf && (crc_byte == CRC32_RESIDUE);

   // Input pin register
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         s_dv <= 1'b0;
         s_d  <= 2'b00;
      end else begin
         s_dv <= CRS_DV;
         s_d  <= {RX1, RX0};
      end
   end

   // FSM state register
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state and per-dibit control strobes
   always_comb begin
      state_d   = state_q;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
      byte_done = 1'b0;
      eof_set   = 1'b0;
      align_err = 1'b0;
      ovf       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (s_dv && s_d == PREAMBLE_DIBIT) state_d = S_PRE;
         end
         S_PRE: begin
            if (!s_dv) begin
               state_d = S_IDLE;
            end else if (s_d == PREAMBLE_DIBIT) begin
               state_d = S_PRE;
            end else if (s_d == SFD_DIBIT &&
                         pre_cnt >= 5'(PREAMBLE_MIN)) begin
               state_d = S_DATA;
               crc_clr = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (!s_dv) begin
               state_d   = S_IDLE;
               eof_set   = 1'b1;
               align_err = (phase != 2'd0);
            end else begin
               crc_en = 1'b1;
               if (phase == 2'd3) begin
                  if (byte_cnt == 11'(MAX_FRAME)) begin
                     ovf     = 1'b1;
                     eof_set = 1'b1;
                     state_d = S_DROP;
                  end else begin
                     byte_done = 1'b1;
                  end
               end
            end
         end
         S_DROP: begin
            if (!s_dv) state_d = S_IDLE;
         end
      endcase
   end

   // Preamble counter, dibit assembler, length counter, CRC snapshot
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt  <= 5'd0;
         phase    <= 2'd0;
         byte_cnt <= 11'd0;
         byte_sr  <= 6'd0;
         crc_lat  <= CRC32_INIT;
      end else begin
         if (state_q == S_IDLE)
            pre_cnt <= 5'd1;
         else if (state_q == S_PRE && s_d == PREAMBLE_DIBIT &&
                  pre_cnt != 5'd31)
            pre_cnt <= pre_cnt + 5'd1;
         if (crc_clr) begin
            phase    <= 2'd0;
            byte_cnt <= 11'd0;
         end else if (crc_en) begin
            phase   <= phase + 2'd1;
            byte_sr <= {s_d, byte_sr[5:2]};
         end
         if (byte_done) byte_cnt <= byte_cnt + 11'd1;
         if (state_q == S_DATA && phase == 2'd0) crc_lat <= crc_state;
      end
   end

   // Byte stream and end-of-frame status outputs
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         rx.rx_data   <= 8'd0;
         rx.rx_valid  <= 1'b0;
         rx.rx_sof    <= 1'b0;
         rx.rx_eof    <= 1'b0;
         rx.rx_crc_ok <= 1'b0;
         rx.rx_err    <= 1'b0;
         rx.frame_len <= 11'd0;
         rx.frame_cnt <= 16'd0;
      end else begin
         rx.rx_valid <= byte_done;
         rx.rx_sof   <= byte_done && (byte_cnt == 11'd0);
         rx.rx_eof   <= eof_set;
         if (byte_done) rx.rx_data <= {s_d, byte_sr};
         if (eof_set) begin
            rx.frame_len <= byte_cnt;
            rx.rx_err    <= err_d;
            rx.rx_crc_ok <= ok_d;
            if (ok_d && !err_d) rx.frame_cnt <= rx.frame_cnt + 16'd1;
         end
      end
   end

endmodule
